// File: rtl/filter_frame_sequencer.sv
// Raster tracker for the filter datapath: pixel coordinates, line/frame strobes,
// KxK window qualifier, per-frame filter mode and geometry error checking.
module filter_frame_sequencer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int KERNEL_SIZE = 3
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       iVGA_HS,
  input  logic       iVGA_VS,
  input  logic       iVGA_BLANK_N,
  input  logic [1:0] mode_req,
  output logic [1:0] mode,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pixel_valid,
  output logic       window_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       line_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_VBLANK,
    ST_ACTIVE,
    ST_HBLANK
  } state_t;

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  localparam logic [9:0] X_WIN  = 10'(KERNEL_SIZE - 1);
  localparam logic [8:0] Y_WIN  = 9'(KERNEL_SIZE - 1);

  state_t     r_state, w_stateNext;
  logic       r_vsD, r_blankD;
  logic [1:0] r_mode, w_modeNext;
  logic [9:0] r_x, w_xNext;
  logic [8:0] r_y, w_yNext;
  logic       r_pixelValid, w_pixelValidNext;
  logic       r_windowValid, w_windowValidNext;
  logic       r_lineStart, w_lineStartNext;
  logic       r_frameStart, w_frameStartNext;
  logic       r_locked, w_lockedNext;
  logic       r_lineErr, w_lineErrNext;
  logic [7:0] r_errCount, w_errCountNext;
  logic       w_vsFall, w_blankRise, w_blankFall;
  logic       w_err, w_errFromVs;

  assign w_vsFall    = r_vsD & ~iVGA_VS;
  assign w_blankRise = ~r_blankD & iVGA_BLANK_N;
  assign w_blankFall = r_blankD & ~iVGA_BLANK_N;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_state       <= ST_UNLOCKED;
      r_vsD         <= 1'b1;
      r_blankD      <= 1'b0;
      r_mode        <= 2'd0;
      r_x           <= 10'd0;
      r_y           <= 9'd0;
      r_pixelValid  <= 1'b0;
      r_windowValid <= 1'b0;
      r_lineStart   <= 1'b0;
      r_frameStart  <= 1'b0;
      r_locked      <= 1'b0;
      r_lineErr     <= 1'b0;
      r_errCount    <= 8'd0;
    end else begin
      r_state       <= w_stateNext;
      r_vsD         <= iVGA_VS;
      r_blankD      <= iVGA_BLANK_N;
      r_mode        <= w_modeNext;
      r_x           <= w_xNext;
      r_y           <= w_yNext;
      r_pixelValid  <= w_pixelValidNext;
      r_windowValid <= w_windowValidNext;
      r_lineStart   <= w_lineStartNext;
      r_frameStart  <= w_frameStartNext;
      r_locked      <= w_lockedNext;
      r_lineErr     <= w_lineErrNext;
      r_errCount    <= w_errCountNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_modeNext       = r_mode;
    w_xNext          = r_x;
    w_yNext          = r_y;
    w_pixelValidNext = 1'b0;
    w_lineStartNext  = 1'b0;
    w_frameStartNext = 1'b0;
    w_lockedNext     = r_locked;
    w_lineErrNext    = 1'b0;
    w_errCountNext   = r_errCount;
    w_err            = 1'b0;
    w_errFromVs      = 1'b0;

    case (r_state)
      ST_UNLOCKED: begin
        if (w_vsFall) w_stateNext = ST_VBLANK;
      end
      // A blank_rise wins over a coincident vs_fall: the frame is starting.
      ST_VBLANK: begin
        if (w_blankRise) begin
          if (!iVGA_HS) begin
            w_err = 1'b1;
          end else begin
            w_stateNext      = ST_ACTIVE;
            w_xNext          = 10'd0;
            w_yNext          = 9'd0;
            w_modeNext       = mode_req;
            w_pixelValidNext = 1'b1;
            w_frameStartNext = 1'b1;
            w_lineStartNext  = 1'b1;
          end
        end
      end
      // r_x is the index of the last pixel seen, so the line length is r_x+1.
      ST_ACTIVE: begin
        if (w_vsFall) begin
          w_err       = 1'b1;
          w_errFromVs = 1'b1;
        end else if (iVGA_BLANK_N) begin
          if (r_x == X_LAST) begin
            w_err = 1'b1;
          end else begin
            w_xNext          = r_x + 10'd1;
            w_pixelValidNext = 1'b1;
          end
        end else if (w_blankFall) begin
          if (r_x == X_LAST) w_stateNext = ST_HBLANK;
          else               w_err       = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (w_vsFall) begin
          if (r_y == Y_LAST) begin
            w_stateNext  = ST_VBLANK;
            w_lockedNext = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_errFromVs = 1'b1;
          end
        end else if (w_blankRise) begin
          if (!iVGA_HS || r_y >= Y_LAST) begin
            w_err = 1'b1;
          end else begin
            w_stateNext      = ST_ACTIVE;
            w_xNext          = 10'd0;
            w_yNext          = r_y + 9'd1;
            w_pixelValidNext = 1'b1;
            w_lineStartNext  = 1'b1;
          end
        end
      end
      default: w_stateNext = ST_UNLOCKED;
    endcase

    if (w_err) begin
      w_lineErrNext    = 1'b1;
      w_errCountNext   = (r_errCount == 8'hFF) ? r_errCount : r_errCount + 8'd1;
      w_lockedNext     = 1'b0;
      w_pixelValidNext = 1'b0;
      w_lineStartNext  = 1'b0;
      w_frameStartNext = 1'b0;
      w_stateNext      = w_errFromVs ? ST_VBLANK : ST_UNLOCKED;
    end

    w_windowValidNext = w_pixelValidNext && (w_xNext >= X_WIN) && (w_yNext >= Y_WIN);
  end

  assign mode         = r_mode;
  assign x            = r_x;
  assign y            = r_y;
  assign pixel_valid  = r_pixelValid;
  assign window_valid = r_windowValid;
  assign line_start   = r_lineStart;
  assign frame_start  = r_frameStart;
  assign locked       = r_locked;
  assign line_err     = r_lineErr;
  assign err_count    = r_errCount;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer on a tiny 8x4 raster with a 3x3 window:
// a vector table for reset/first pixels, then hand-built frames for the multi-cycle cases.
module tb_filter_frame_sequencer;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int KSIZE  = 3;

  logic       VGA_CLK;
  logic       reset;
  logic       iHs, iVs, iBlankN;
  logic [1:0] modeReq;
  logic [1:0] mode;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_valid, window_valid, line_start, frame_start, locked, line_err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;
  int lsCnt    = 0;
  int wvCnt    = 0;
  int fsCnt    = 0;
  int leCnt    = 0;

  filter_frame_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .KERNEL_SIZE(KSIZE)) dut (
    .VGA_CLK      (VGA_CLK),
    .reset        (reset),
    .iVGA_HS      (iHs),
    .iVGA_VS      (iVs),
    .iVGA_BLANK_N (iBlankN),
    .mode_req     (modeReq),
    .mode         (mode),
    .x            (x),
    .y            (y),
    .pixel_valid  (pixel_valid),
    .window_valid (window_valid),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .locked       (locked),
    .line_err     (line_err),
    .err_count    (err_count)
  );

  initial VGA_CLK = 1'b0;
  always #20 VGA_CLK = ~VGA_CLK;

  // Pulse tallies sampled mid-cycle; tests compare before/after snapshots.
  always @(negedge VGA_CLK) begin
    lsCnt <= lsCnt + int'(line_start);
    wvCnt <= wvCnt + int'(window_valid);
    fsCnt <= fsCnt + int'(frame_start);
    leCnt <= leCnt + int'(line_err);
  end

  typedef struct {
    logic       rst, hs, vs, bn;
    logic [1:0] mreq;
    logic       pv;
    logic [9:0] ex;
    logic [8:0] ey;
    logic       fs, ls, wv, le, lk;
    logic [1:0] md;
    logic [7:0] ec;
  } vec_t;

  function automatic vec_t mkVec(logic rst, logic hs, logic vs, logic bn, logic [1:0] mreq,
                                 logic pv, logic [9:0] ex, logic [8:0] ey, logic fs, logic ls,
                                 logic wv, logic le, logic lk, logic [1:0] md, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.hs = hs; v.vs = vs; v.bn = bn; v.mreq = mreq;
    v.pv = pv; v.ex = ex; v.ey = ey; v.fs = fs; v.ls = ls;
    v.wv = wv; v.le = le; v.lk = lk; v.md = md; v.ec = ec;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic hs, input logic vs, input logic bn);
    reset   = rst;
    iHs     = hs;
    iVs     = vs;
    iBlankN = bn;
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic vsPulse(input logic expErr, input logic expLocked);
    applyStimulus(0, 1, 0, 0);
    checkOutput("vsFallErrLocked", {line_err, locked}, {expErr, expLocked});
    applyStimulus(0, 1, 0, 0);
  endtask

  // One frame of nLines lines; line badLine (if any) is badLen pixels long.
  task automatic driveFrame(input int nLines, input int badLine, input int badLen,
                            input logic [1:0] expMode, input int changeLine, input logic [1:0] newReq);
    bit errored;
    int len;
    errored = 0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);
    for (int l = 0; l < nLines; l++) begin
      if (l == changeLine) modeReq = newReq;
      len = (l == badLine) ? badLen : WIDTH;
      for (int p = 0; p < len; p++) begin
        applyStimulus(0, 1, 1, 1);
        if (errored)
          checkOutput("pixelValidAfterErr", pixel_valid, 1'b0);
        else
          checkOutput("pixel", {pixel_valid, x, y, frame_start, line_start, window_valid, mode},
                      {1'b1, 10'(p), 9'(l), (l == 0 && p == 0), (p == 0),
                       (p >= KSIZE - 1 && l >= KSIZE - 1), expMode});
      end
      applyStimulus(0, 1, 1, 0);
      if (l == badLine) begin
        checkOutput("shortLineErr", {line_err, locked, pixel_valid}, 3'b100);
        errored = 1;
      end
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0);
    end
  endtask

  task automatic errLoop();
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 1, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    int ls0, wv0, fs0, le0;

    reset = 1'b1; iHs = 1'b1; iVs = 1'b1; iBlankN = 1'b0; modeReq = 2'd0;

    vecs[0] = mkVec(1, 1, 1, 0, 2'd1, 0, 10'd0, 9'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    vecs[1] = mkVec(0, 1, 0, 0, 2'd1, 0, 10'd0, 9'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    vecs[2] = mkVec(0, 1, 1, 0, 2'd1, 0, 10'd0, 9'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    vecs[3] = mkVec(0, 1, 1, 1, 2'd1, 1, 10'd0, 9'd0, 1, 1, 0, 0, 0, 2'd1, 8'd0);
    vecs[4] = mkVec(0, 1, 1, 1, 2'd1, 1, 10'd1, 9'd0, 0, 0, 0, 0, 0, 2'd1, 8'd0);
    vecs[5] = mkVec(0, 1, 1, 1, 2'd2, 1, 10'd2, 9'd0, 0, 0, 0, 0, 0, 2'd1, 8'd0);
    vecs[6] = mkVec(1, 1, 1, 1, 2'd2, 0, 10'd0, 9'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    vecs[7] = mkVec(0, 1, 1, 0, 2'd0, 0, 10'd0, 9'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0);

    for (int i = 0; i < 8; i++) begin
      modeReq = vecs[i].mreq;
      applyStimulus(vecs[i].rst, vecs[i].hs, vecs[i].vs, vecs[i].bn);
      checkOutput($sformatf("vec%0d", i),
                  {pixel_valid, x, y, frame_start, line_start, window_valid, line_err, locked, mode, err_count},
                  {vecs[i].pv, vecs[i].ex, vecs[i].ey, vecs[i].fs, vecs[i].ls, vecs[i].wv,
                   vecs[i].le, vecs[i].lk, vecs[i].md, vecs[i].ec});
    end

    // Clean frame from reset, then lock on the closing vs_fall.
    vsPulse(0, 0);
    ls0 = lsCnt; wv0 = wvCnt; fs0 = fsCnt; le0 = leCnt;
    driveFrame(4, -1, 0, 2'd0, -1, 2'd0);
    checkOutput("frame1Counts", {16'(lsCnt - ls0), 16'(wvCnt - wv0), 16'(fsCnt - fs0), 16'(leCnt - le0)},
                {16'd4, 16'd12, 16'd1, 16'd0});
    vsPulse(0, 1);
    checkOutput("errCountClean", err_count, 8'd0);

    // mode_req changes mid-frame; applied only at the next frame_start.
    driveFrame(4, -1, 0, 2'd0, 2, 2'd2);
    checkOutput("modeHeldMidFrame", mode, 2'd0);
    vsPulse(0, 1);
    ls0 = lsCnt; wv0 = wvCnt; fs0 = fsCnt; le0 = leCnt;
    driveFrame(4, -1, 0, 2'd2, -1, 2'd0);
    checkOutput("frame3Counts", {16'(lsCnt - ls0), 16'(wvCnt - wv0), 16'(fsCnt - fs0), 16'(leCnt - le0)},
                {16'd4, 16'd12, 16'd1, 16'd0});
    vsPulse(0, 1);

    // Short line: error, unlocked until the next frame, then re-lock.
    driveFrame(4, 1, 7, 2'd2, -1, 2'd0);
    checkOutput("errCountShort", {err_count, locked, pixel_valid}, {8'd1, 1'b0, 1'b0});
    vsPulse(0, 0);
    driveFrame(4, -1, 0, 2'd2, -1, 2'd0);
    vsPulse(0, 1);

    // vs_fall after three lines: error straight into VBLANK.
    ls0 = lsCnt; wv0 = wvCnt;
    driveFrame(3, -1, 0, 2'd2, -1, 2'd0);
    checkOutput("frame3LineCounts", {16'(lsCnt - ls0), 16'(wvCnt - wv0)}, {16'd3, 16'd6});
    vsPulse(1, 0);
    checkOutput("errCountEarlyVs", err_count, 8'd2);
    driveFrame(4, -1, 0, 2'd2, -1, 2'd0);
    vsPulse(0, 1);

    // Saturate err_count with HS-low blank_rise errors.
    for (int i = 0; i < 252; i++) errLoop();
    checkOutput("errCount254", err_count, 8'd254);
    errLoop();
    checkOutput("errCount255", err_count, 8'd255);
    errLoop();
    checkOutput("errCountSaturated", {err_count, locked}, {8'd255, 1'b0});

    // Reset in the middle of a line clears everything.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    for (int p = 0; p < 3; p++) applyStimulus(0, 1, 1, 1);
    checkOutput("preResetPixel", {pixel_valid, x, mode}, {1'b1, 10'd2, 2'd2});
    applyStimulus(1, 1, 1, 1);
    checkOutput("midLineReset",
                {pixel_valid, x, y, frame_start, line_start, window_valid, line_err, locked, mode, err_count},
                35'd0);
    applyStimulus(0, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
